instruction_fetch_unit: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the pipelined MIPS core. It holds the PC, runs a request/valid handshake with instruction memory, buffers a returned word while decode is stalled, and squashes wrong-path fetches on a redirect. Its registered outputs feed `instruction_decoder` directly: register addresses, rd, and the 16-bit immediate field.

---
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Request/valid handshake between the fetch stage and imem.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module      : instruction_fetch_unit
// Description : MIPS fetch stage with IF/ID register, stall buffer, redirect drain.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    stall,
    input  wire logic                    redirect,
    input  wire logic [31:0]             redirect_target,
    instruction_fetch_unit_if.master     imem,
    output logic                         if_id_valid,
    output logic [31:0]                  if_id_inst,
    output logic [31:0]                  if_id_pc_plus4,
    output logic [4:0]                   if_id_rs,
    output logic [4:0]                   if_id_rt,
    output logic [4:0]                   if_id_rd,
    output logic [15:0]                  if_id_imm,
    output logic [31:0]                  fetch_count
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_buf, hold_nxt;
    logic [31:0] pending, pending_nxt;
    logic        ifid_load;
    logic        ifid_flush;
    logic [31:0] ifid_data;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;
    assign target   = redirect_target & ~32'h0000_0003;

    assign imem.imem_req  = !reset && (state != S_HOLD);
    assign imem.imem_addr = pc;

    assign if_id_rs  = if_id_inst[25:21];
    assign if_id_rt  = if_id_inst[20:16];
    assign if_id_rd  = if_id_inst[15:11];
    assign if_id_imm = if_id_inst[15:0];

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        hold_nxt    = hold_buf;
        pending_nxt = pending;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_data   = imem.imem_rdata;

        if (redirect) begin
            ifid_flush = 1'b1;
            hold_nxt   = 32'h0;
            case (state)
                S_REQ: begin
                    if (imem.imem_valid) begin
                        pc_nxt = target;
                    end else begin
                        // Response still in flight: park the target until it drains.
                        pending_nxt = target;
                        state_nxt   = S_DRAIN;
                    end
                end
                S_HOLD: begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end
                default: begin
                    pending_nxt = target;
                    if (imem.imem_valid) begin
                        pc_nxt    = target;
                        state_nxt = S_REQ;
                    end
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem.imem_valid) begin
                        if (stall) begin
                            hold_nxt  = imem.imem_rdata;
                            state_nxt = S_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_nxt    = pc_plus4;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ifid_data = hold_buf;
                        pc_nxt    = pc_plus4;
                        state_nxt = S_REQ;
                    end
                end
                default: begin
                    if (imem.imem_valid) begin
                        pc_nxt    = pending;
                        state_nxt = S_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            hold_buf       <= 32'h0;
            pending        <= 32'h0;
            if_id_valid    <= 1'b0;
            if_id_inst     <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            fetch_count    <= 32'h0;
        end else begin
            pc       <= pc_nxt;
            hold_buf <= hold_nxt;
            pending  <= pending_nxt;
            if (ifid_flush) begin
                if_id_valid <= 1'b0;
                if_id_inst  <= 32'h0;
            end else if (ifid_load) begin
                if_id_valid    <= 1'b1;
                if_id_inst     <= ifid_data;
                if_id_pc_plus4 <= pc_plus4;
                fetch_count    <= fetch_count + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench for instruction_fetch_unit with hand-computed values.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic [4:0]  if_id_rd;
    logic [15:0] if_id_imm;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    instruction_fetch_unit_if imem ();

    instruction_fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem           (imem.master),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .if_id_rd       (if_id_rd),
        .if_id_imm      (if_id_imm),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] rd, input logic st,
                       input logic rdr, input logic [31:0] tgt);
        imem.imem_valid = v;
        imem.imem_rdata = rd;
        stall           = st;
        redirect        = rdr;
        redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = 32'h0;

        // Reset state
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_fields", {if_id_rs, if_id_rt, if_id_rd, if_id_imm[0]}, 32'h0);
        chk("rst_req_in_reset", {31'h0, imem.imem_req}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_req_after", {31'h0, imem.imem_req}, 32'h1);
        chk("rst_addr_after", imem.imem_addr, 32'h0);

        // Zero-wait memory returning addr + 0x100
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        chk("zw_inst0", if_id_inst, 32'h0000_0100);
        chk("zw_pc4_0", if_id_pc_plus4, 32'h4);
        chk("zw_addr1", imem.imem_addr, 32'h4);
        cyc(1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0);
        chk("zw_inst1", if_id_inst, 32'h0000_0104);
        chk("zw_pc4_1", if_id_pc_plus4, 32'h8);
        cyc(1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'h0);
        chk("zw_inst2", if_id_inst, 32'h0000_0108);
        chk("zw_pc4_2", if_id_pc_plus4, 32'hC);
        chk("zw_count", fetch_count, 32'd3);
        chk("zw_valid", {31'h0, if_id_valid}, 32'h1);

        // Stall as 0x2012_0005 returns from address 0xC
        cyc(1'b1, 32'h2012_0005, 1'b1, 1'b0, 32'h0);
        chk("st_inst_held", if_id_inst, 32'h0000_0108);
        chk("st_req_low", {31'h0, imem.imem_req}, 32'h0);
        chk("st_count_held", fetch_count, 32'd3);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st_inst_still", if_id_inst, 32'h0000_0108);
        chk("st_req_still", {31'h0, imem.imem_req}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("st_rel_inst", if_id_inst, 32'h2012_0005);
        chk("st_rel_rs", {27'h0, if_id_rs}, 32'd0);
        chk("st_rel_rt", {27'h0, if_id_rt}, 32'd18);
        chk("st_rel_imm", {16'h0, if_id_imm}, 32'd5);
        chk("st_rel_pc4", if_id_pc_plus4, 32'h10);
        chk("st_rel_count", fetch_count, 32'd4);
        chk("st_rel_req", {31'h0, imem.imem_req}, 32'h1);
        chk("st_rel_addr", imem.imem_addr, 32'h10);

        // Redirect during a 3-cycle memory wait
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("dr_wait_addr", imem.imem_addr, 32'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
        chk("dr_flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("dr_flush_inst", if_id_inst, 32'h0);
        chk("dr_old_addr", imem.imem_addr, 32'h10);
        chk("dr_req", {31'h0, imem.imem_req}, 32'h1);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("dr_drop_valid", {31'h0, if_id_valid}, 32'h0);
        chk("dr_drop_inst", if_id_inst, 32'h0);
        chk("dr_drop_count", fetch_count, 32'd4);
        chk("dr_new_addr", imem.imem_addr, 32'h40);

        // Redirect together with stall and imem_valid
        cyc(1'b1, 32'h8C22_0010, 1'b0, 1'b0, 32'h0);
        chk("sim_pre_inst", if_id_inst, 32'h8C22_0010);
        chk("sim_pre_pc4", if_id_pc_plus4, 32'h44);
        cyc(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0080);
        chk("sim_flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("sim_flush_inst", if_id_inst, 32'h0);
        chk("sim_req", {31'h0, imem.imem_req}, 32'h1);
        chk("sim_addr", imem.imem_addr, 32'h80);
        cyc(1'b1, 32'h0000_1111, 1'b0, 1'b0, 32'h0);
        chk("sim_next_inst", if_id_inst, 32'h0000_1111);
        chk("sim_next_pc4", if_id_pc_plus4, 32'h84);
        chk("sim_count", fetch_count, 32'd6);

        // Unaligned redirect near the top of the address space, then wrap
        cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wr_addr", imem.imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h0000_2222, 1'b0, 1'b0, 32'h0);
        chk("wr_inst", if_id_inst, 32'h0000_2222);
        chk("wr_pc4", if_id_pc_plus4, 32'h0);
        chk("wr_next_addr", imem.imem_addr, 32'h0);
        chk("wr_count", fetch_count, 32'd7);

        // Reset while in S_HOLD
        cyc(1'b1, 32'h0000_3333, 1'b1, 1'b0, 32'h0);
        chk("rh_hold_req", {31'h0, imem.imem_req}, 32'h0);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("rh_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rh_inst", if_id_inst, 32'h0);
        chk("rh_count", fetch_count, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("rh_req", {31'h0, imem.imem_req}, 32'h1);
        chk("rh_addr", imem.imem_addr, 32'h0);

        // Reset while in S_DRAIN
        cyc(1'b1, 32'h0000_4444, 1'b0, 1'b0, 32'h0);
        chk("rd_pre_count", fetch_count, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        chk("rd_drain_addr", imem.imem_addr, 32'h4);
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rd_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rd_count", fetch_count, 32'h0);
        reset = 1'b0;
        #1;
        chk("rd_addr", imem.imem_addr, 32'h0);
        cyc(1'b1, 32'h0000_5555, 1'b0, 1'b0, 32'h0);
        chk("rd_fetch_inst", if_id_inst, 32'h0000_5555);
        chk("rd_fetch_pc4", if_id_pc_plus4, 32'h4);
        chk("rd_fetch_count", fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
